// File: rtl/rr_arbiter8_pkg.sv
// Shared constants and types for the 8-way round-robin arbiter.
package rr_arbiter8_pkg;

    // Number of requesters and width of an index into them.
    localparam int N_REQ = 8;
    localparam int SEL_W = 3;

    // Arbiter FSM states. IDLE means nobody owns the resource.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_e;

    // Index that follows i in the circular search order (7 wraps to 0).
    function automatic logic [SEL_W-1:0] next_idx(input logic [SEL_W-1:0] i);
        return i + 1'b1;
    endfunction

endpackage

// File: rtl/rr_arbiter8_if.sv
// Request/grant bundle between the requesting units and the arbiter.
//
// Handshake: a requester holds req[k] high for as long as it wants the
// resource; it owns the resource in every cycle where gnt[k] is high.
// There is no separate acknowledge -- dropping req[k] is the release, and
// the arbiter may move the grant elsewhere at that same edge.
interface rr_arbiter8_if;
    import rr_arbiter8_pkg::*;

    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] gnt;
    logic [SEL_W-1:0] sel;
    logic             busy;
    logic             preempt;

    // Requesting side drives req and observes the arbitration result.
    modport master (
        output req,
        input  gnt,
        input  sel,
        input  busy,
        input  preempt
    );

    // Arbiter side.
    modport slave (
        input  req,
        output gnt,
        output sel,
        output busy,
        output preempt
    );

endinterface

// File: rtl/DMux8Way.sv
// 1-to-8 demultiplexer: routes `in` to the output selected by sel, all
// other outputs are 0.
module DMux8Way (
    input  logic       in,
    input  logic [2:0] sel,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       d,
    output logic       e,
    output logic       f,
    output logic       g,
    output logic       h
);

    // Plain decode of sel gated by in.
    always_comb begin
        a = in & (sel == 3'd0);
        b = in & (sel == 3'd1);
        c = in & (sel == 3'd2);
        d = in & (sel == 3'd3);
        e = in & (sel == 3'd4);
        f = in & (sel == 3'd5);
        g = in & (sel == 3'd6);
        h = in & (sel == 3'd7);
    end

endmodule

// File: rtl/rr_pick8.sv
// Combinational round-robin search: first set request bit starting at
// `start` and wrapping 7 -> 0. With mask_self set, the bit just before
// start (the current owner) is skipped so only competitors are found.
module rr_pick8
    import rr_arbiter8_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic             mask_self,
    input  logic [SEL_W-1:0] start,
    output logic             found,
    output logic [SEL_W-1:0] idx
);

    logic [SEL_W-1:0] cand;
    logic [SEL_W-1:0] self_idx;

    // Walk the eight positions in search order and keep the first hit.
    always_comb begin
        found    = 1'b0;
        idx      = start;
        cand     = start;
        self_idx = start - 1'b1;
        for (int i = 0; i < N_REQ; i++) begin
            cand = start + SEL_W'(i);
            if (!found && req[cand] && !(mask_self && (cand == self_idx))) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/rr_arbiter8.sv
// 8-way round-robin arbiter with a bounded hold time per owner.
//
// The owner keeps the grant while it requests. If a competitor is waiting,
// the owner is preempted after MAX_HOLD consecutive cycles and drops to the
// lowest priority. Release hands over at the same edge (no idle bubble).
// sel/busy are registered; gnt is their one-hot decode, so all outputs
// change only at the clock edge.
module rr_arbiter8
    import rr_arbiter8_pkg::*;
#(
    parameter int MAX_HOLD = 8,   // 1..255
    parameter int CNT_W    = 8    // 2**CNT_W > MAX_HOLD
) (
    input  logic                clk,
    input  logic                reset,
    rr_arbiter8_if.slave        bus,
    output arb_state_e          dbg_state
);

    // Last hold_cnt value an owner may reach before a competitor takes over.
    localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(MAX_HOLD - 1);

    arb_state_e       state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [SEL_W-1:0] last_q, last_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic             preempt_q, preempt_d;

    logic             pick_found;
    logic [SEL_W-1:0] pick_idx;
    logic             busy;
    logic [N_REQ-1:0] gnt_w;

    // In GRANT last == sel, so searching from last+1 with the owner masked
    // finds the next competitor; in IDLE the same search finds the next
    // requester after the most recent owner (requester 0 after reset).
    rr_pick8 u_pick (
        .req       (bus.req),
        .mask_self (state_q == ST_GRANT),
        .start     (next_idx(last_q)),
        .found     (pick_found),
        .idx       (pick_idx)
    );

    // Next-state logic for ownership, hold counter and preempt pulse.
    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        last_d     = last_q;
        hold_cnt_d = hold_cnt_q;
        preempt_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    state_d    = ST_GRANT;
                    sel_d      = pick_idx;
                    last_d     = pick_idx;
                    hold_cnt_d = '0;
                end
            end

            ST_GRANT: begin
                if (!bus.req[sel_q]) begin
                    // Release: hand over directly, or go idle keeping sel.
                    hold_cnt_d = '0;
                    if (pick_found) begin
                        sel_d  = pick_idx;
                        last_d = pick_idx;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (!pick_found) begin
                    // Uncontended: keep the grant, counter saturates so a
                    // later competitor still has to wait at most one cycle.
                    if (hold_cnt_q != HOLD_LIM) begin
                        hold_cnt_d = hold_cnt_q + 1'b1;
                    end
                end else if (hold_cnt_q == HOLD_LIM) begin
                    // Contended and out of time: rotate to the competitor.
                    sel_d      = pick_idx;
                    last_d     = pick_idx;
                    hold_cnt_d = '0;
                    preempt_d  = 1'b1;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers with synchronous reset; reset drops any grant at once.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            sel_q      <= '0;
            last_q     <= SEL_W'(N_REQ - 1);
            hold_cnt_q <= '0;
            preempt_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            last_q     <= last_d;
            hold_cnt_q <= hold_cnt_d;
            preempt_q  <= preempt_d;
        end
    end

    assign busy = (state_q == ST_GRANT);

    // One-hot grant: busy steered to the owner's line.
    DMux8Way u_dmux (
        .in  (busy),
        .sel (sel_q),
        .a   (gnt_w[0]),
        .b   (gnt_w[1]),
        .c   (gnt_w[2]),
        .d   (gnt_w[3]),
        .e   (gnt_w[4]),
        .f   (gnt_w[5]),
        .g   (gnt_w[6]),
        .h   (gnt_w[7])
    );

    assign bus.gnt     = gnt_w;
    assign bus.sel     = sel_q;
    assign bus.busy    = busy;
    assign bus.preempt = preempt_q;
    assign dbg_state   = state_q;

endmodule
